fp_divider: RTL and testbench
=============================

FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  32  IEEE-754 single-precision dividend.
REQ-006 B  input  32  IEEE-754 single-precision divisor.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when Output is valid.
REQ-009 Output  output  32  quotient A/B; held from the done pulse until the next accepted start.

Function
REQ-010 In IDLE, start=1 SHALL capture A and B; start while busy SHALL be ignored, with no queuing.
REQ-011 Unpack: exponent field 0 SHALL give exponent 1 with hidden bit 0 (denormal); otherwise the hidden bit SHALL be 1. Sign = A[31] XOR B[31].
REQ-012 Special cases SHALL be checked in the capture cycle, in this priority order, and SHALL bypass NORM/DIV straight to PACK:
- Either operand NaN, 0/0, or inf/inf -> 0x7FC00000.
- A inf or B zero -> signed infinity.
- A zero or B inf -> signed zero.
REQ-013 NORM SHALL left-shift each denormal mantissa one bit per cycle until bit23=1, decrementing that operand's exponent per shift; it SHALL take 1 cycle when both operands are already normal and at most 24 cycles otherwise.
REQ-014 Working exponent SHALL be a 10-bit signed value: eA - eB + 127.
REQ-015 DIV SHALL perform restoring division for exactly 25 cycles, producing one quotient bit per cycle into q[24:0]; q[24] has weight 2^0.
REQ-016 PACK:
- q[24]=1 -> mantissa = q[23:1].
- q[24]=0 -> mantissa = q[22:0] and exponent - 1.
- Rounding SHALL be truncation.
REQ-017 Packed exponent >= 255 SHALL give signed infinity; exponent <= 0 SHALL flush to signed zero (no denormal outputs).
REQ-018 State machine SHALL have states IDLE, NORM, DIV, PACK:
- IDLE -> NORM on start with no special case.
- IDLE -> PACK on start with a special case.
- NORM -> DIV when both mantissas are normalized.
- DIV -> PACK after iteration 25.
- PACK -> IDLE, registering Output and pulsing done.
REQ-019 Latency, counting the start-sampling edge as edge 1: normal operands SHALL raise done after edge 28; special cases after edge 2; a denormal operand SHALL add (shifts-1) edges.
REQ-020 done SHALL be high for exactly one cycle, coincident with the return to IDLE; a start sampled in that same cycle SHALL be accepted.

Reset
REQ-021 Reset SHALL set: state=IDLE, busy=0, done=0, Output=0x00000000, iteration counter=0, datapath registers=0.
REQ-022 Reset asserted mid-operation SHALL abort it with no done pulse; after reset release, the first start SHALL behave as from power-up.

Structure
REQ-023 A shared package fp_pkg SHALL hold: EXP_BIAS=127, MANT_W=23, EXP_W=8, QNAN=0x7FC00000, POS_INF=0x7F800000, DIV_ITERS=25, and the state enumeration.
REQ-024 Sub-module fp_unpack (combinational: sign, exponent, mantissa with hidden bit, is_zero/is_inf/is_nan) SHALL be instantiated twice; the FSM and datapath SHALL live in fp_divider.

Verification
REQ-025 A=0x40C00000 (6.0), B=0x40000000 (2.0), start -> Output=0x40400000, done after edge 28, busy high edges 1-27.
REQ-026 A=0x3F800000, B=0x40400000 (1/3) -> Output=0x3EAAAAAA (truncated).
REQ-027 Specials:
- A=0xBF800000, B=0x00000000 -> 0xFF800000 at edge 2.
- A=0x00000000, B=0x00000000 -> 0x7FC00000.
REQ-028 Range limits:
- A=0x7F000000, B=0x00800000 -> 0x7F800000 (overflow).
- A=0x00000001, B=0x3F800000 -> 0x00000000 (flush), done after edge 50.
REQ-029 Start pulsed again at edge 10 of an operation -> ignored; result and timing identical to REQ-025.
REQ-030 Reset asserted at edge 15 of an operation -> no done; busy=0 and Output=0 immediately; a fresh 6.0/2.0 afterwards completes per REQ-025.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the single-precision divider.
package fp_pkg;
  localparam int          EXP_BIAS  = 127;
  localparam int          MANT_W    = 23;
  localparam int          EXP_W     = 8;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;
  localparam int          DIV_ITERS = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DIV  = 2'd2,
    PACK = 2'd3
  } state_t;
endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single into sign, effective exponent and mantissa with hidden bit,
// and flags zero / infinity / NaN.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       val,
  output logic              sign,
  output logic [EXP_W-1:0]  expo,
  output logic [MANT_W:0]   mant,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] frac;

  assign sign  = val[31];
  assign exp_f = val[30:23];
  assign frac  = val[22:0];

  // Denormals use exponent 1 with a zero hidden bit.
  assign expo    = (exp_f == '0) ? EXP_W'(1) : exp_f;
  assign mant    = {(exp_f != '0), frac};
  assign is_zero = (exp_f == '0) && (frac == '0);
  assign is_inf  = (&exp_f) && (frac == '0);
  assign is_nan  = (&exp_f) && (frac != '0);

endmodule

// File: rtl/fp_divider.sv
// Multi-cycle IEEE-754 single-precision divider: capture, normalize denormals,
// 25-step restoring mantissa division, pack with truncation and flush-to-zero.
module fp_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Output
);

  state_t state, state_n;

  logic              ua_sign, ub_sign, ua_zero, ub_zero, ua_inf, ub_inf, ua_nan, ub_nan;
  logic [EXP_W-1:0]  ua_exp, ub_exp;
  logic [MANT_W:0]   ua_mant, ub_mant;

  logic              sign_q, special_q;
  logic [31:0]       special_res;
  logic signed [9:0] ea, eb, ea_n, eb_n;
  logic [23:0]       ma, mb, ma_n, mb_n;
  logic [24:0]       rem, rem_sub, q;
  logic              q_bit;
  logic [4:0]        cnt;

  logic              res_sign, spec_hit;
  logic [31:0]       spec_val;
  logic signed [9:0] exp_w, exp_p;
  logic [22:0]       mant_p;
  logic [31:0]       packed_res;

  fp_unpack u_unpack_a (
    .val     (A),
    .sign    (ua_sign),
    .expo    (ua_exp),
    .mant    (ua_mant),
    .is_zero (ua_zero),
    .is_inf  (ua_inf),
    .is_nan  (ua_nan)
  );

  fp_unpack u_unpack_b (
    .val     (B),
    .sign    (ub_sign),
    .expo    (ub_exp),
    .mant    (ub_mant),
    .is_zero (ub_zero),
    .is_inf  (ub_inf),
    .is_nan  (ub_nan)
  );

  assign res_sign = ua_sign ^ ub_sign;

  always_comb begin
    spec_hit = 1'b1;
    spec_val = QNAN;
    if (ua_nan || ub_nan || (ua_zero && ub_zero) || (ua_inf && ub_inf))
      spec_val = QNAN;
    else if (ua_inf || ub_zero)
      spec_val = {res_sign, POS_INF[30:0]};
    else if (ua_zero || ub_inf)
      spec_val = {res_sign, 31'b0};
    else
      spec_hit = 1'b0;
  end

  // One normalizing shift per cycle for whichever mantissa still lacks bit 23.
  always_comb begin
    ma_n = ma;
    eb_n = eb;
    ea_n = ea;
    mb_n = mb;
    if (!ma[23]) begin
      ma_n = ma << 1;
      ea_n = ea - 10'sd1;
    end
    if (!mb[23]) begin
      mb_n = mb << 1;
      eb_n = eb - 10'sd1;
    end
  end

  always_comb begin
    q_bit   = (rem >= {1'b0, mb});
    rem_sub = q_bit ? (rem - {1'b0, mb}) : rem;
  end

  always_comb begin
    exp_w  = ea - eb + 10'(EXP_BIAS);
    exp_p  = q[24] ? exp_w : (exp_w - 10'sd1);
    mant_p = q[24] ? q[23:1] : q[22:0];
    if (exp_p >= 10'sd255)
      packed_res = {sign_q, POS_INF[30:0]};
    else if (exp_p <= 10'sd0)
      packed_res = {sign_q, 31'b0};
    else
      packed_res = {sign_q, exp_p[7:0], mant_p};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    case (state)
      IDLE: if (start) state_n = spec_hit ? PACK : NORM;
      NORM: if (ma_n[23] && mb_n[23]) state_n = DIV;
      DIV:  if (cnt == '0) state_n = PACK;
      PACK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done        <= 1'b0;
      Output      <= '0;
      sign_q      <= 1'b0;
      special_q   <= 1'b0;
      special_res <= '0;
      ea          <= '0;
      eb          <= '0;
      ma          <= '0;
      mb          <= '0;
      rem         <= '0;
      q           <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sign_q      <= res_sign;
          special_q   <= spec_hit;
          special_res <= spec_val;
          ea          <= {2'b00, ua_exp};
          eb          <= {2'b00, ub_exp};
          ma          <= ua_mant;
          mb          <= ub_mant;
          cnt         <= '0;
        end
        NORM: begin
          ma <= ma_n;
          mb <= mb_n;
          ea <= ea_n;
          eb <= eb_n;
          if (ma_n[23] && mb_n[23]) begin
            rem <= {1'b0, ma_n};
            q   <= '0;
            cnt <= 5'(DIV_ITERS - 1);
          end
        end
        DIV: begin
          rem <= rem_sub << 1;
          q   <= {q[23:0], q_bit};
          if (cnt != '0) cnt <= cnt - 5'd1;
        end
        PACK: begin
          Output <= special_q ? special_res : packed_res;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: exact-arithmetic reference model, directed corner
// cases, mid-operation start/reset, and randomized operand streams.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] Output;

  fp_divider dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Output (Output)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, expv);
    end
  endtask

  // Reference: true quotient of the raw significands, truncated to 24 significant bits.
  function automatic int lead_shifts(input logic [31:0] x);
    logic [23:0] m;
    int n;
    m = {(x[30:23] != 8'd0), x[22:0]};
    n = 0;
    while (!m[23] && n < 24) begin
      m = m << 1;
      n++;
    end
    return n;
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat);
    logic s, za, zb, ia, ib, na, nb;
    logic [127:0] ma, mb, num, den, n;
    int ea, eb, kk, e, sh;
    bit found;
    s  = a[31] ^ b[31];
    za = (a[30:0] == 31'd0);
    zb = (b[30:0] == 31'd0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    lat = 2;
    if (na || nb || (za && zb) || (ia && ib)) res = 32'h7FC0_0000;
    else if (ia || zb)                       res = {s, 31'h7F80_0000};
    else if (za || ib)                       res = {s, 31'd0};
    else begin
      ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
      eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
      ma = {104'd0, (a[30:23] != 8'd0), a[22:0]};
      mb = {104'd0, (b[30:23] != 8'd0), b[22:0]};
      den = mb << 24;
      found = 0;
      kk = 0;
      n = '0;
      for (int k = -24; k <= 80; k++) begin
        if (!found) begin
          num = ma << (k + 24);
          if (num / den >= 128'd8388608) begin
            n = num / den;
            kk = k;
            found = 1;
          end
        end
      end
      e = 23 - kk + ea - eb + 127;
      if (e >= 255)     res = {s, 31'h7F80_0000};
      else if (e <= 0)  res = {s, 31'd0};
      else              res = {s, e[7:0], n[22:0]};
      sh = lead_shifts(a);
      if (lead_shifts(b) > sh) sh = lead_shifts(b);
      lat = 27 + ((sh > 1) ? sh : 1);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 with Output 0x%08h, required no done", Output);
      end else begin
        mon_e = sb.pop_front();
        chk("result", Output, mon_e.res);
        chk("latency", 32'(cyc - mon_e.t0 + 1), 32'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int g;
    g = 0;
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got busy=1 required 0");
    end else begin
      A = a;
      B = b;
      start = 1'b1;
      model(a, b, e.res, e.lat);
      e.t0 = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 5))
      1: r[30:23] = 8'($urandom_range(100, 154));
      2: begin
        r[30:23] = 8'd0;
        r[22:0]  = r[22:0] >> $urandom_range(0, 22);
        if (r[22:0] == 23'd0) r[0] = 1'b1;
      end
      3: case ($urandom_range(0, 4))
        0: r[30:0] = 31'd0;
        1: r[30:0] = 31'h7F80_0000;
        2: r[30:0] = 31'h7FC0_0000;
        3: r[30:0] = 31'h7F80_0001;
        default: r[30:0] = 31'h3F80_0000;
      endcase
      4: r[30:23] = $urandom_range(0, 1) ? 8'($urandom_range(1, 12)) : 8'($urandom_range(243, 254));
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, g;
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_output", Output, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 6.0 / 2.0 with busy-window measurement
    issue(32'h40C0_0000, 32'h4000_0000);
    chk("model_6_div_2", sb[0].res, 32'h4040_0000);
    bc = 0;
    g = 0;
    while (!done && g < 100) begin
      if (busy) bc++;
      @(negedge clk);
      g++;
    end
    chk("busy_cycles", 32'(bc), 32'd27);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    drain();

    issue(32'h3F80_0000, 32'h4040_0000);
    issue(32'hBF80_0000, 32'h0000_0000);
    issue(32'h0000_0000, 32'h0000_0000);
    issue(32'h7F00_0000, 32'h0080_0000);
    issue(32'h0000_0001, 32'h3F80_0000);
    issue(32'h7F80_0000, 32'h7F80_0000);
    issue(32'h4000_0000, 32'h7F80_0000);
    issue(32'h0040_0000, 32'h0020_0000);
    drain();

    // Second start during the operation must be ignored
    issue(32'h40C0_0000, 32'h4000_0000);
    repeat (8) @(negedge clk);
    A = 32'h3F80_0000;
    B = 32'h0000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // Reset mid-operation aborts without a done pulse
    issue(32'h40C0_0000, 32'h4000_0000);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_output", Output, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    issue(32'h40C0_0000, 32'h4000_0000);
    drain();

    repeat (200) issue(rand_fp(), rand_fp());
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
